cop_issue_ctrl: RTL
===================

Name: cop_issue_ctrl

Overview:
- Upstream issue/writeback controller between the core's custom-instruction port and the Ascon ISE co-processor interface.
- Latches one core request and drives it onto the co-processor (cop_*) bus. Waits out cop_wait, captures the result, and holds it in a response register until the core writeback stage accepts it.
- Guards against a hung co-processor with a wait watchdog, and counts retired writes.

Parameters:
- XLEN, 64, data width of rs1/rs2/rd.
- MAX_WAIT, 255, cycles cop_wait may stay high in EXEC before the watchdog aborts; must be ≥1.
- CNT_W, 32, width of the retired-write counter.

Ports:
- cop_clk  in  1  clock.
- cop_rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  core offers an instruction.
- req_ready  out  1  controller accepts the request this cycle.
- req_insn  in  32  instruction word.
- req_rs1  in  XLEN  operand 1.
- req_rs2  in  XLEN  operand 2.
- rsp_valid  out  1  response register is full.
- rsp_ready  in  1  writeback accepts the response.
- rsp_wen  out  1  response carries a register write.
- rsp_rd_idx  out  5  destination register, from latched insn[11:7].
- rsp_data  out  XLEN  result; 0 when rsp_wen=0.
- rsp_err  out  1  watchdog abort.
- cop_valid  out  1  request to the co-processor.
- cop_rdywr  out  1  controller can take a write result.
- cop_insn  out  32  latched instruction.
- cop_rs1  out  XLEN  latched operand 1.
- cop_rs2  out  XLEN  latched operand 2.
- cop_ready  in  1  co-processor not stalling.
- cop_wait  in  1  co-processor multi-cycle busy.
- cop_wr  in  1  co-processor produces a write.
- cop_rd  in  XLEN  co-processor result.
- busy  out  1  state ≠ IDLE.
- wr_count  out  CNT_W  retired writes.

Behaviour:
- Reset (async, immediate): state=IDLE.
  - Latched insn/rs1/rs2 = 0.
  - Response register (wen, idx, data, err) = 0; rsp_valid=0.
  - Watchdog counter = 0; wr_count = 0.
  - Hence cop_valid=0, busy=0, req_ready=1.
  - Reset mid-operation drops the in-flight transaction; no response is produced.
- States: IDLE, EXEC, RESP.
- req_ready = (state==IDLE) | (state==RESP & rsp_ready).
- Accept on req_valid & req_ready:
  - Latch req_insn, req_rs1, req_rs2; clear the watchdog counter.
  - Next state = EXEC.
- IDLE:
  - Without accept, stay.
- EXEC:
  - cop_valid=1; cop_insn/rs1/rs2 = latched values; cop_rdywr=1.
  - If cop_wait=1: increment the watchdog.
    - When the counter reaches MAX_WAIT, abort: rsp_wen=0, rsp_data=0, rsp_err=1; go RESP.
  - Else if cop_ready=1: capture rsp_wen=cop_wr, rsp_data = cop_wr ? cop_rd : 0, rsp_err=0, rsp_rd_idx=insn[11:7]; go RESP.
    - Instructions the co-processor does not claim (cop_wr=0) complete as non-writing.
  - Else (cop_ready=0): stay; the watchdog does not count.
  - Minimum EXEC duration is 1 cycle.
- RESP:
  - cop_valid=0, cop_rdywr=0.
  - rsp_valid=1; response fields are stable while rsp_ready=0.
  - On rsp_ready: if req_valid, accept the new request and go EXEC (back-to-back); else go IDLE.
  - rsp_valid drops the cycle after the handshake unless a new response is captured.
- Throughput and latency:
  - Peak throughput is one instruction per 2 cycles.
  - Latency from accept to rsp_valid is 1 + wait cycles.
- wr_count:
  - Increments by 1 on each RESP handshake with rsp_wen=1; aborts do not count.
  - Wraps modulo 2^CNT_W.
- Inputs req_* are ignored whenever req_ready=0.
- cop_rd, cop_wr and cop_wait are ignored outside EXEC.
- busy = (state≠IDLE).

Decomposition:
- Shared package cop_pkg:
  - State encoding localparams: IDLE=2'd0, EXEC=2'd1, RESP=2'd2.
  - CUSTOM_0..3 opcode constants.
  - Rd field slice position (11:7).
- One natural sub-module, cop_rsp_reg: response holding register with valid/ready and load/clear. All other logic stays flat.

Test Plan:
- Single write:
  - Stimulus: req insn=0x4A00_152B, rs1=0x1, rs2=0x0; cop_wr=1, cop_rd=0xDEAD_BEEF_0123_4567, cop_wait=0, rsp_ready=1.
  - Required: rsp_valid 1 cycle after accept with rsp_wen=1, rsp_rd_idx=10, rsp_data=0xDEADBEEF01234567; wr_count=1.
- Non-claimed instruction:
  - Stimulus: insn=0x0000_0033; cop_wr=0.
  - Required: rsp_wen=0, rsp_data=0, rsp_err=0; wr_count unchanged.
- Backpressure and back-to-back:
  - Stimulus: hold rsp_ready=0 for 5 cycles, then 1 with req_valid high.
  - Required: rsp_data stable for all 5 cycles; req_ready=1 only in the handshake cycle; next cop_valid asserts the following cycle.
- Wait then complete:
  - Stimulus: cop_wait=1 for 10 cycles, then 0.
  - Required: cop_valid held 11 cycles; normal response; rsp_err=0.
- Watchdog:
  - Stimulus: MAX_WAIT=4, cop_wait stuck at 1.
  - Required: after 4 wait cycles, RESP with rsp_err=1, rsp_wen=0; wr_count unchanged.
- Reset mid-EXEC:
  - Stimulus: assert cop_rst asynchronously during EXEC.
  - Required: outputs return to reset values immediately (cop_valid=0, rsp_valid=0, req_ready=1); after release, no stale response appears.

Source files
------------

// File: rtl/cop_pkg.sv
// cop_pkg: shared constants and types for the Ascon ISE co-processor issue controller.
package cop_pkg;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic [6:0] CUSTOM_0 = 7'h0B;
    localparam logic [6:0] CUSTOM_1 = 7'h2B;
    localparam logic [6:0] CUSTOM_2 = 7'h5B;
    localparam logic [6:0] CUSTOM_3 = 7'h7B;

    localparam int RD_MSB = 11;
    localparam int RD_LSB = 7;

    typedef struct packed {
        logic       wen;
        logic [4:0] idx;
        logic       err;
    } rsp_meta_t;

    function automatic logic [4:0] rd_of(input logic [31:0] insn);
        return insn[RD_MSB:RD_LSB];
    endfunction
endpackage

// File: rtl/cop_rsp_reg.sv
// cop_rsp_reg: response holding register; load fills it, clear (handshake) empties it.
module cop_rsp_reg
    import cop_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            load_i,
    input  logic            clear_i,
    input  logic            wen_i,
    input  logic [4:0]      idx_i,
    input  logic [XLEN-1:0] data_i,
    input  logic            err_i,
    output logic            valid_o,
    output logic            wen_o,
    output logic [4:0]      idx_o,
    output logic [XLEN-1:0] data_o,
    output logic            err_o
);
    logic            valid_q;
    rsp_meta_t       meta_q;
    logic [XLEN-1:0] data_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            meta_q  <= '0;
            data_q  <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            meta_q  <= '{wen: wen_i, idx: idx_i, err: err_i};
            data_q  <= wen_i ? data_i : '0;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign wen_o   = meta_q.wen;
    assign idx_o   = meta_q.idx;
    assign err_o   = meta_q.err;
    assign data_o  = data_q;
endmodule

// File: rtl/cop_issue_ctrl.sv
// cop_issue_ctrl: issues one core custom instruction to the co-processor and holds its result
// until writeback accepts it; a watchdog aborts when cop_wait stays high too long.
module cop_issue_ctrl
    import cop_pkg::*;
#(
    parameter int XLEN     = 64,
    parameter int MAX_WAIT = 255,
    parameter int CNT_W    = 32
) (
    input  logic             cop_clk,
    input  logic             cop_rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_insn,
    input  logic [XLEN-1:0]  req_rs1,
    input  logic [XLEN-1:0]  req_rs2,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_wen,
    output logic [4:0]       rsp_rd_idx,
    output logic [XLEN-1:0]  rsp_data,
    output logic             rsp_err,
    output logic             cop_valid,
    output logic             cop_rdywr,
    output logic [31:0]      cop_insn,
    output logic [XLEN-1:0]  cop_rs1,
    output logic [XLEN-1:0]  cop_rs2,
    input  logic             cop_ready,
    input  logic             cop_wait,
    input  logic             cop_wr,
    input  logic [XLEN-1:0]  cop_rd,
    output logic             busy,
    output logic [CNT_W-1:0] wr_count
);
    localparam int WD_W = $clog2(MAX_WAIT + 1);

    logic [1:0]       state_q, state_d;
    logic [31:0]      insn_q;
    logic [XLEN-1:0]  rs1_q, rs2_q;
    logic [WD_W-1:0]  wdog_q, wdog_d, wdog_inc;
    logic [CNT_W-1:0] cnt_q;
    logic             in_exec, hs, accept, abort, load;

    assign in_exec   = state_q == EXEC;
    assign hs        = (state_q == RESP) & rsp_ready;
    assign req_ready = (state_q == IDLE) | hs;
    assign accept    = req_valid & req_ready;
    assign wdog_inc  = wdog_q + 1'b1;
    assign abort     = in_exec & cop_wait & (wdog_inc == WD_W'(MAX_WAIT));
    // A stalled co-processor (cop_ready=0 without cop_wait) is not counted by the watchdog.
    assign load      = abort | (in_exec & ~cop_wait & cop_ready);

    always_comb begin
        state_d = (state_q == 2'd3) ? IDLE : state_q;
        wdog_d  = wdog_q;
        if (accept) begin
            state_d = EXEC;
            wdog_d  = '0;
        end else if (load) begin
            state_d = RESP;
        end else if (hs) begin
            state_d = IDLE;
        end else if (in_exec & cop_wait) begin
            wdog_d = wdog_inc;
        end
    end

    always_ff @(posedge cop_clk or posedge cop_rst) begin
        if (cop_rst) begin
            state_q <= IDLE;
            insn_q  <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            wdog_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            wdog_q  <= wdog_d;
            cnt_q   <= cnt_q + CNT_W'(hs & rsp_wen);
            if (accept) begin
                insn_q <= req_insn;
                rs1_q  <= req_rs1;
                rs2_q  <= req_rs2;
            end
        end
    end

    cop_rsp_reg #(.XLEN(XLEN)) u_rsp (
        .clk_i   (cop_clk),
        .rst_i   (cop_rst),
        .load_i  (load),
        .clear_i (hs),
        .wen_i   (cop_wr & ~abort),
        .idx_i   (rd_of(insn_q)),
        .data_i  (cop_rd),
        .err_i   (abort),
        .valid_o (rsp_valid),
        .wen_o   (rsp_wen),
        .idx_o   (rsp_rd_idx),
        .data_o  (rsp_data),
        .err_o   (rsp_err)
    );

    assign cop_valid = in_exec;
    assign cop_rdywr = in_exec;
    assign cop_insn  = insn_q;
    assign cop_rs1   = rs1_q;
    assign cop_rs2   = rs2_q;
    assign busy      = state_q != IDLE;
    assign wr_count  = cnt_q;
endmodule
